instruction_fetch_unit: RTL and testbench



---
 rtl/riscv_fetch_pkg.sv | 17 +
 rtl/fetch_buffer.sv | 64 ++++++
 rtl/instruction_fetch_unit.sv | 149 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_fetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
package riscv_fetch_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    // Width of a counter able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO holding fetched {instruction, pc} entries.
module fetch_buffer
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 96
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        i_push,
    input  logic [WIDTH-1:0]            i_push_data,
    input  logic                        i_pop,
    input  logic                        i_flush,
    output logic [cnt_width(DEPTH)-1:0] o_count,
    output logic [WIDTH-1:0]            o_head
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    // A push into a full buffer is only honoured when a pop frees a slot.
    assign w_do_pop  = i_pop && (r_count != CW'(0));
    assign w_do_push = i_push && ((r_count != CW'(DEPTH)) || w_do_pop);

    // Storage, pointers and occupancy; flush empties the buffer in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr] <= i_push_data;
                r_wr_ptr <= (r_wr_ptr == PW'(DEPTH - 1)) ? PW'(0) : r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= (r_rd_ptr == PW'(DEPTH - 1)) ? PW'(0) : r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = (r_count != CW'(0)) ? r_mem[r_rd_ptr] : '0;

endmodule

// File: rtl/instruction_fetch_unit.sv
// PC generation, credit-limited in-order fetch requests and redirect/drain control
// feeding a small instruction buffer towards decode.
module instruction_fetch_unit
    import riscv_fetch_pkg::*;
#(
    parameter int unsigned         WORDSIZE = 64,
    parameter int unsigned         SIZE     = 32,
    parameter logic [WORDSIZE-1:0] RESET_PC = '0,
    parameter int unsigned         DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic                imem_req_valid,
    input  logic                imem_req_ready,
    output logic [WORDSIZE-1:0] imem_addr,
    input  logic                imem_rsp_valid,
    input  logic [SIZE-1:0]     imem_rsp_data,
    input  logic                redirect_valid,
    input  logic [WORDSIZE-1:0] redirect_pc,
    output logic                instr_valid,
    input  logic                instr_ready,
    output logic [SIZE-1:0]     instruction,
    output logic [WORDSIZE-1:0] instr_pc
);

    localparam int unsigned CW = cnt_width(DEPTH);
    localparam int unsigned EW = SIZE + WORDSIZE;
    localparam logic [WORDSIZE-1:0] PC_STEP = WORDSIZE'(INSTR_BYTES);

    fetch_state_e        r_state;
    fetch_state_e        w_state_next;
    logic [WORDSIZE-1:0] r_fetch_pc;
    logic [WORDSIZE-1:0] w_fetch_pc_next;
    logic [WORDSIZE-1:0] r_rsp_pc;
    logic [WORDSIZE-1:0] w_rsp_pc_next;
    logic [CW-1:0]       r_outstanding;
    logic [CW-1:0]       w_outstanding_next;
    logic [CW-1:0]       r_stale;
    logic [CW-1:0]       w_stale_next;
    logic                r_run_en;

    logic [CW-1:0]       w_count;
    logic [EW-1:0]       w_head;
    logic [CW:0]         w_in_use;
    logic [CW:0]         w_stale_sum;
    logic [WORDSIZE-1:0] w_redirect_aligned;
    logic                w_req_fire;
    logic                w_push;
    logic                w_pop;

    assign w_in_use           = {1'b0, r_outstanding} + {1'b0, w_count};
    assign w_redirect_aligned = redirect_pc & ~WORDSIZE'(3);
    // Requests issued before the redirect still come back and must be discarded.
    assign w_stale_sum        = {1'b0, r_stale} + {1'b0, r_outstanding}
                              - {{CW{1'b0}}, imem_rsp_valid};

    // r_run_en holds requests off for the first cycle after reset release.
    assign imem_req_valid = r_run_en && (r_state == RUN) && !redirect_valid
                         && (w_in_use < (CW + 1)'(DEPTH));
    assign imem_addr      = r_fetch_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_push         = imem_rsp_valid && (r_state == RUN) && !redirect_valid;
    assign instr_valid    = (w_count != CW'(0));
    assign w_pop          = instr_valid && instr_ready && !redirect_valid;

    fetch_buffer #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fetch_buffer (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (w_push),
        .i_push_data ({imem_rsp_data, r_rsp_pc}),
        .i_pop       (w_pop),
        .i_flush     (redirect_valid),
        .o_count     (w_count),
        .o_head      (w_head)
    );

    assign instruction = w_head[EW-1:WORDSIZE];
    assign instr_pc    = w_head[WORDSIZE-1:0];

    // Next-state, PC and credit counter logic; redirect overrides everything.
    always_comb begin
        w_state_next       = r_state;
        w_fetch_pc_next    = r_fetch_pc;
        w_rsp_pc_next      = r_rsp_pc;
        w_outstanding_next = r_outstanding;
        w_stale_next       = r_stale;
        if (redirect_valid) begin
            w_fetch_pc_next    = w_redirect_aligned;
            w_rsp_pc_next      = w_redirect_aligned;
            w_outstanding_next = '0;
            w_stale_next       = w_stale_sum[CW-1:0];
            w_state_next       = (w_stale_sum != '0) ? DRAIN : RUN;
        end else begin
            case (r_state)
                RUN: begin
                    if (w_req_fire) begin
                        w_fetch_pc_next = r_fetch_pc + PC_STEP;
                    end else begin
                        w_fetch_pc_next = r_fetch_pc;
                    end
                    if (imem_rsp_valid) begin
                        w_rsp_pc_next = r_rsp_pc + PC_STEP;
                    end else begin
                        w_rsp_pc_next = r_rsp_pc;
                    end
                    case ({w_req_fire, imem_rsp_valid})
                        2'b10:   w_outstanding_next = r_outstanding + CW'(1);
                        2'b01:   w_outstanding_next = r_outstanding - CW'(1);
                        default: w_outstanding_next = r_outstanding;
                    endcase
                end
                DRAIN: begin
                    if (imem_rsp_valid && (r_stale != CW'(0))) begin
                        w_stale_next = r_stale - CW'(1);
                    end else begin
                        w_stale_next = r_stale;
                    end
                    w_state_next = (w_stale_next == CW'(0)) ? RUN : DRAIN;
                end
                default: begin
                    w_state_next = RUN;
                end
            endcase
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_fetch_pc    <= RESET_PC;
            r_rsp_pc      <= RESET_PC;
            r_outstanding <= '0;
            r_stale       <= '0;
            r_run_en      <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_fetch_pc    <= w_fetch_pc_next;
            r_rsp_pc      <= w_rsp_pc_next;
            r_outstanding <= w_outstanding_next;
            r_stale       <= w_stale_next;
            r_run_en      <= 1'b1;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a simple in-order memory responder.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [63:0] instr_pc;

    logic        rsp_hold;
    logic [63:0] pend_q[$];
    int          tests;
    int          fails;

    instruction_fetch_unit #(
        .WORDSIZE (64),
        .SIZE     (32),
        .RESET_PC (64'h0),
        .DEPTH    (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instruction    (instruction),
        .instr_pc       (instr_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'h0)      return 32'h00A0_0093;
        else if (a == 64'h4) return 32'h0010_8113;
        else                 return {4'h1, a[27:0]};
    endfunction

    // Memory: record accepted requests mid-cycle, answer one cycle later in order.
    always @(negedge clk) begin
        if (rst_n && imem_req_valid && imem_req_ready) pend_q.push_back(imem_addr);
    end

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            pend_q.delete();
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end else if (pend_q.size() > 0 && !rsp_hold) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_q.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'h0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic do_reset(input logic req_rdy, input logic dec_rdy, input logic hold);
        rst_n          = 1'b0;
        imem_req_ready = req_rdy;
        instr_ready    = dec_rdy;
        rsp_hold       = hold;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        tests          = 0;
        fails          = 0;
        rst_n          = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        rsp_hold       = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;

        // Reset values
        mid();
        check("rst_req_valid", imem_req_valid, 64'h0);
        check("rst_instr_valid", instr_valid, 64'h0);
        check("rst_instruction", instruction, 64'h0);
        check("rst_instr_pc", instr_pc, 64'h0);
        check("rst_addr", imem_addr, 64'h0);

        // Streaming fetch with decode always ready
        do_reset(1'b1, 1'b1, 1'b0);
        step(); mid();
        check("s1_c1_req_valid", imem_req_valid, 64'h1);
        check("s1_c1_addr", imem_addr, 64'h0);
        step(); mid();
        check("s1_c2_addr", imem_addr, 64'h4);
        step(); mid();
        check("s1_c3_instr_valid", instr_valid, 64'h1);
        check("s1_c3_instruction", instruction, 64'h00A0_0093);
        check("s1_c3_instr_pc", instr_pc, 64'h0);
        check("s1_c3_req_valid", imem_req_valid, 64'h0);
        step(); mid();
        check("s1_c4_instruction", instruction, 64'h0010_8113);
        check("s1_c4_instr_pc", instr_pc, 64'h4);
        check("s1_c4_addr", imem_addr, 64'h8);

        // Decode stalled: credit stops fetch after two requests
        do_reset(1'b1, 1'b0, 1'b0);
        step(); step(); step(); step(); mid();
        check("s2_c4_req_valid", imem_req_valid, 64'h0);
        check("s2_c4_instr_pc", instr_pc, 64'h0);
        step();
        instr_ready = 1'b1;
        mid();
        check("s2_c5_req_valid", imem_req_valid, 64'h0);
        step(); mid();
        check("s2_c6_instruction", instruction, 64'h0010_8113);
        check("s2_c6_instr_pc", instr_pc, 64'h4);
        check("s2_c6_addr", imem_addr, 64'h8);
        check("s2_c6_req_valid", imem_req_valid, 64'h1);
        step(); mid();
        check("s2_c7_instr_valid", instr_valid, 64'h0);
        check("s2_c7_instruction_zero", instruction, 64'h0);
        step(); mid();
        check("s2_c8_instr_pc", instr_pc, 64'h8);
        check("s2_c8_instruction", instruction, 64'h1000_0008);

        // Memory not ready: request held stable, single handshake
        do_reset(1'b0, 1'b1, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            step(); mid();
            check("s3_hold_valid", imem_req_valid, 64'h1);
            check("s3_hold_addr", imem_addr, 64'h0);
        end
        step();
        imem_req_ready = 1'b1;
        mid();
        check("s3_c4_addr", imem_addr, 64'h0);
        step(); mid();
        check("s3_c5_addr", imem_addr, 64'h4);
        step(); mid();
        check("s3_c6_instr_pc", instr_pc, 64'h0);
        check("s3_c6_instruction", instruction, 64'h00A0_0093);
        step(); mid();
        check("s3_c7_instr_pc", instr_pc, 64'h4);
        check("s3_c7_instruction", instruction, 64'h0010_8113);

        // Redirect with two requests in flight, misaligned target
        do_reset(1'b1, 1'b1, 1'b1);
        step(); step(); step(); mid();
        check("s4_c3_req_valid", imem_req_valid, 64'h0);
        step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h103;
        mid();
        check("s4_c4_req_valid", imem_req_valid, 64'h0);
        step();
        redirect_valid = 1'b0;
        rsp_hold       = 1'b0;
        mid();
        check("s4_c5_req_valid", imem_req_valid, 64'h0);
        check("s4_c5_addr", imem_addr, 64'h100);
        check("s4_c5_instr_valid", instr_valid, 64'h0);
        step(); mid();
        check("s4_c6_req_valid", imem_req_valid, 64'h0);
        step(); mid();
        check("s4_c7_req_valid", imem_req_valid, 64'h0);
        check("s4_c7_instr_valid", instr_valid, 64'h0);
        step(); mid();
        check("s4_c8_req_valid", imem_req_valid, 64'h1);
        check("s4_c8_addr", imem_addr, 64'h100);
        step(); mid();
        check("s4_c9_instr_valid", instr_valid, 64'h0);
        step(); mid();
        check("s4_c10_instr_valid", instr_valid, 64'h1);
        check("s4_c10_instr_pc", instr_pc, 64'h100);
        check("s4_c10_instruction", instruction, 64'h1000_0100);

        // Redirect coinciding with a response and a pop
        do_reset(1'b1, 1'b1, 1'b0);
        step(); step(); step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h200;
        mid();
        check("s5_c3_instr_valid", instr_valid, 64'h1);
        check("s5_c3_rsp_valid", imem_rsp_valid, 64'h1);
        step();
        redirect_valid = 1'b0;
        mid();
        check("s5_c4_instr_valid", instr_valid, 64'h0);
        check("s5_c4_req_valid", imem_req_valid, 64'h1);
        check("s5_c4_addr", imem_addr, 64'h200);
        step(); mid();
        check("s5_c5_instr_valid", instr_valid, 64'h0);
        step(); mid();
        check("s5_c6_instr_pc", instr_pc, 64'h200);
        check("s5_c6_instruction", instruction, 64'h1000_0200);

        // Asynchronous reset while draining with one stale response left
        do_reset(1'b1, 1'b1, 1'b1);
        step(); step(); step(); step();
        redirect_valid = 1'b1;
        redirect_pc    = 64'h100;
        step();
        redirect_valid = 1'b0;
        rsp_hold       = 1'b0;
        step(); step();
        rst_n = 1'b0;
        #1;
        check("s6_rst_req_valid", imem_req_valid, 64'h0);
        check("s6_rst_addr", imem_addr, 64'h0);
        check("s6_rst_instr_valid", instr_valid, 64'h0);
        check("s6_rst_instruction", instruction, 64'h0);
        check("s6_rst_instr_pc", instr_pc, 64'h0);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        step(); mid();
        check("s6_c1_req_valid", imem_req_valid, 64'h1);
        check("s6_c1_addr", imem_addr, 64'h0);
        step(); mid();
        check("s6_c2_addr", imem_addr, 64'h4);
        step(); step(); mid();
        check("s6_c4_instr_pc", instr_pc, 64'h4);
        check("s6_c4_instruction", instruction, 64'h0010_8113);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
